// File: rtl/rom_dl_router_if.sv
// Download-side bundle: the HPS ioctl byte stream, both SDRAM request/ack
// ports and the PROM write port. The router uses master, its surroundings use slave.
`timescale 1ns/1ps
interface rom_dl_router_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;

    logic        port1_req;
    logic        port1_ack;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port1_we;

    logic        port2_req;
    logic        port2_ack;
    logic [22:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;
    logic        port2_we;

    logic        prom_wr;
    logic [11:0] prom_addr;
    logic [7:0]  prom_data;

    modport master (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output ioctl_wait,
        output port1_req, port1_a, port1_ds, port1_d, port1_we,
        input  port1_ack,
        output port2_req, port2_a, port2_ds, port2_d, port2_we,
        input  port2_ack,
        output prom_wr, prom_addr, prom_data
    );

    modport slave (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ioctl_wait,
        input  port1_req, port1_a, port1_ds, port1_d, port1_we,
        output port1_ack,
        input  port2_req, port2_a, port2_ds, port2_d, port2_we,
        output port2_ack,
        input  prom_wr, prom_addr, prom_data
    );
endinterface

// File: rtl/rom_dl_router.sv
// Routes HPS ioctl download bytes to the SDRAM ports, the PROM loader and the
// configuration registers, and produces rom_loaded plus the stretched core reset.
`timescale 1ns/1ps
module rom_dl_router #(
    parameter logic [24:0] SPRITE_BASE  = 25'h30000,
    parameter logic [24:0] PROM_BASE    = 25'hA0000,
    parameter logic [11:0] PROM_SIZE    = 12'h920,
    parameter logic [15:0] RESET_CYCLES = 16'hFFFF
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    rom_dl_router_if.master bus,
    input  logic            reset_req,
    output logic [7:0]      core_mod,
    output logic [7:0]      dip0,
    output logic [7:0]      dip1,
    output logic            rom_loaded,
    output logic            core_reset
);

    localparam logic [24:0] PROM_END = PROM_BASE + {13'd0, PROM_SIZE};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic        wr_reg;
    logic        dl_rom_reg;
    logic [24:0] addr_reg;
    logic [7:0]  data_reg;
    logic        we_reg;
    logic        need2_reg;
    logic        req1_reg;
    logic        req2_reg;
    logic        load_pending_reg;
    logic        rom_loaded_reg;
    logic [15:0] counter_reg;
    logic        core_reset_reg;
    logic [7:0]  core_mod_reg;
    logic [7:0]  dip0_reg;
    logic [7:0]  dip1_reg;

    logic        dl_rom;
    logic        wr_edge;
    logic        rom_edge;
    logic        mod_edge;
    logic        dip_edge;
    logic        dl_fall;
    logic        load_hit;
    logic        in_sprite;
    logic        in_prom;
    logic        ack_done;
    logic [23:0] sprite_off;
    logic [11:0] prom_off;

    logic        wait_out;
    logic        prom_pulse;
    logic        issue;

    assign dl_rom   = bus.ioctl_download & (bus.ioctl_index == 8'd0);
    assign wr_edge  = bus.ioctl_wr & ~wr_reg;
    assign rom_edge = wr_edge & dl_rom;
    assign mod_edge = wr_edge & (bus.ioctl_index == 8'd1);
    assign dip_edge = wr_edge & (bus.ioctl_index == 8'd254) & (bus.ioctl_addr[24:3] == 22'd0);
    assign dl_fall  = dl_rom_reg & ~dl_rom;
    assign load_hit = dl_fall | load_pending_reg;

    assign in_sprite = (addr_reg >= SPRITE_BASE) && (addr_reg < PROM_BASE);
    assign in_prom   = (addr_reg >= PROM_BASE) && (addr_reg < PROM_END);

    // Only the low bits of each offset are ever used, so the subtraction is
    // done at that width; the carry out of the top never reaches them.
    assign sprite_off = addr_reg[23:0] - SPRITE_BASE[23:0];
    assign prom_off   = addr_reg[11:0] - PROM_BASE[11:0];

    assign ack_done = (bus.port1_ack == req1_reg) &&
                      (!need2_reg || (bus.port2_ack == req2_reg));

    // FSM state register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (rom_edge) state_next = ISSUE;
            ISSUE:    state_next = WAIT_ACK;
            WAIT_ACK: if (ack_done) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        wait_out   = 1'b0;
        prom_pulse = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            ISSUE: begin
                wait_out   = 1'b1;
                issue      = 1'b1;
                prom_pulse = in_prom;
            end
            WAIT_ACK: wait_out = 1'b1;
            default: ;
        endcase
    end

    // Holding register and request toggles
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_reg     <= 1'b0;
            dl_rom_reg <= 1'b0;
            addr_reg   <= 25'd0;
            data_reg   <= 8'd0;
            we_reg     <= 1'b0;
            need2_reg  <= 1'b0;
            req1_reg   <= 1'b0;
            req2_reg   <= 1'b0;
        end else begin
            wr_reg     <= bus.ioctl_wr;
            dl_rom_reg <= dl_rom;
            if ((state_reg == IDLE) && rom_edge) begin
                addr_reg <= bus.ioctl_addr;
                data_reg <= bus.ioctl_dout;
                we_reg   <= dl_rom;
            end
            if (issue) begin
                req1_reg  <= ~req1_reg;
                need2_reg <= in_sprite;
                if (in_sprite) begin
                    req2_reg <= ~req2_reg;
                end
            end
        end
    end

    // Configuration bytes
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            core_mod_reg <= 8'd0;
            dip0_reg     <= 8'hFF;
            dip1_reg     <= 8'hFF;
        end else begin
            if (mod_edge) begin
                core_mod_reg <= bus.ioctl_dout;
            end
            if (dip_edge && (bus.ioctl_addr[2:0] == 3'd0)) begin
                dip0_reg <= bus.ioctl_dout;
            end
            if (dip_edge && (bus.ioctl_addr[2:0] == 3'd1)) begin
                dip1_reg <= bus.ioctl_dout;
            end
        end
    end

    // A download that ends mid-byte is only complete once that byte is acked.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            load_pending_reg <= 1'b0;
            rom_loaded_reg   <= 1'b0;
            counter_reg      <= RESET_CYCLES;
            core_reset_reg   <= 1'b1;
        end else begin
            if (load_hit) begin
                if (state_next == IDLE) begin
                    rom_loaded_reg   <= 1'b1;
                    load_pending_reg <= 1'b0;
                end else begin
                    load_pending_reg <= 1'b1;
                end
            end
            if (reset_req || !rom_loaded_reg || dl_rom) begin
                counter_reg <= RESET_CYCLES;
            end else if (counter_reg != 16'd0) begin
                counter_reg <= counter_reg - 16'd1;
            end
            core_reset_reg <= (counter_reg != 16'd0);
        end
    end

    assign bus.ioctl_wait = wait_out;

    assign bus.port1_req = req1_reg;
    assign bus.port1_a   = addr_reg[23:1];
    assign bus.port1_ds  = {addr_reg[0], ~addr_reg[0]};
    assign bus.port1_d   = {data_reg, data_reg};
    assign bus.port1_we  = we_reg;

    assign bus.port2_req = req2_reg;
    assign bus.port2_a   = sprite_off[23:1];
    assign bus.port2_ds  = {sprite_off[0], ~sprite_off[0]};
    assign bus.port2_d   = {data_reg, data_reg};
    assign bus.port2_we  = we_reg;

    assign bus.prom_wr   = prom_pulse;
    assign bus.prom_addr = prom_off;
    assign bus.prom_data = data_reg;

    assign core_mod   = core_mod_reg;
    assign dip0       = dip0_reg;
    assign dip1       = dip1_reg;
    assign rom_loaded = rom_loaded_reg;
    assign core_reset = core_reset_reg;

endmodule

// File: tb/tb_rom_dl_router.sv
// Directed bench for rom_dl_router: ROM/sprite/PROM bytes, config bytes,
// rom_loaded and core reset stretching, reset during an outstanding access.
`timescale 1ns/1ps
module tb_rom_dl_router;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       reset_req;
    logic [7:0] core_mod;
    logic [7:0] dip0;
    logic [7:0] dip1;
    logic       rom_loaded;
    logic       core_reset;

    int n_vec = 0;
    int n_err = 0;

    rom_dl_router_if bus();

    rom_dl_router #(.RESET_CYCLES(16'd16)) dut (
        .clk_sys    (clk),
        .reset_n    (rst_n),
        .bus        (bus),
        .reset_req  (reset_req),
        .core_mod   (core_mod),
        .dip0       (dip0),
        .dip1       (dip1),
        .rom_loaded (rom_loaded),
        .core_reset (core_reset)
    );

    always #5 clk = ~clk;

    // SDRAM ack responder: returns each toggle after a programmable delay
    int   p1_delay = 3;
    int   p2_delay = 3;
    logic ack_hold = 1'b0;
    int   cnt1;
    int   cnt2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.port1_ack <= 1'b0;
            bus.port2_ack <= 1'b0;
            cnt1 <= 0;
            cnt2 <= 0;
        end else if (!ack_hold) begin
            if (bus.port1_req != bus.port1_ack) begin
                if (cnt1 >= p1_delay - 1) begin
                    bus.port1_ack <= bus.port1_req;
                    cnt1 <= 0;
                end else cnt1 <= cnt1 + 1;
            end
            if (bus.port2_req != bus.port2_ack) begin
                if (cnt2 >= p2_delay - 1) begin
                    bus.port2_ack <= bus.port2_req;
                    cnt2 <= 0;
                end else cnt2 <= cnt2 + 1;
            end
        end
    end

    // Observations recorded by send_byte
    int          wait_cycles;
    int          prom_pulses;
    int          t1;
    int          t2;
    logic        timed_out;
    logic [22:0] c_p1_a;
    logic [1:0]  c_p1_ds;
    logic [15:0] c_p1_d;
    logic        c_p1_we;
    logic [22:0] c_p2_a;
    logic [1:0]  c_p2_ds;
    logic [15:0] c_p2_d;
    logic [11:0] c_prom_addr;
    logic [7:0]  c_prom_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
        logic r1;
        logic r2;
        bus.ioctl_index = idx;
        bus.ioctl_addr  = addr;
        bus.ioctl_dout  = data;
        bus.ioctl_wr    = 1'b1;
        wait_cycles = 0; prom_pulses = 0; t1 = 0; t2 = 0; timed_out = 1'b0;
        r1 = bus.port1_req;
        r2 = bus.port2_req;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.port1_req != r1) t1++;
            if (bus.port2_req != r2) t2++;
            r1 = bus.port1_req;
            r2 = bus.port2_req;
            if (bus.prom_wr) begin
                prom_pulses++;
                c_prom_addr = bus.prom_addr;
                c_prom_data = bus.prom_data;
            end
            if (bus.ioctl_wait) begin
                if (wait_cycles == 0) begin
                    c_p1_a = bus.port1_a; c_p1_ds = bus.port1_ds; c_p1_d = bus.port1_d; c_p1_we = bus.port1_we;
                    c_p2_a = bus.port2_a; c_p2_ds = bus.port2_ds; c_p2_d = bus.port2_d;
                end
                wait_cycles++;
            end else if (i >= 2) begin
                break;
            end
            if (i == 39) timed_out = 1'b1;
        end
        bus.ioctl_wr = 1'b0;
        tick();
        $display("byte idx=%0d addr=%h data=%h wait=%0d req1_toggles=%0d req2_toggles=%0d prom_pulses=%0d",
                 idx, addr, data, wait_cycles, t1, t2, prom_pulses);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; reset_req = 1'b0;
        bus.ioctl_download = 1'b0; bus.ioctl_index = 8'd1; bus.ioctl_wr = 1'b0;
        bus.ioctl_addr = '0; bus.ioctl_dout = '0;
        repeat (3) tick();
        n_vec++; if (bus.port1_req !== 1'b0) begin n_err++; $display("FAIL rst_port1_req got %b exp 0", bus.port1_req); end
        n_vec++; if (bus.port2_req !== 1'b0) begin n_err++; $display("FAIL rst_port2_req got %b exp 0", bus.port2_req); end
        n_vec++; if (bus.ioctl_wait !== 1'b0) begin n_err++; $display("FAIL rst_wait got %b exp 0", bus.ioctl_wait); end
        n_vec++; if (bus.prom_wr !== 1'b0) begin n_err++; $display("FAIL rst_prom_wr got %b exp 0", bus.prom_wr); end
        n_vec++; if (core_mod !== 8'h00) begin n_err++; $display("FAIL rst_core_mod got %h exp 00", core_mod); end
        n_vec++; if (dip0 !== 8'hFF) begin n_err++; $display("FAIL rst_dip0 got %h exp ff", dip0); end
        n_vec++; if (dip1 !== 8'hFF) begin n_err++; $display("FAIL rst_dip1 got %h exp ff", dip1); end
        n_vec++; if (rom_loaded !== 1'b0) begin n_err++; $display("FAIL rst_rom_loaded got %b exp 0", rom_loaded); end
        n_vec++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL rst_core_reset got %b exp 1", core_reset); end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_config();
        bus.ioctl_download = 1'b1;
        send_byte(8'd1, 25'h0, 8'h0B);
        send_byte(8'd254, 25'h1, 8'h7E);
        n_vec++; if (core_mod !== 8'h0B) begin n_err++; $display("FAIL cfg_core_mod got %h exp 0b", core_mod); end
        n_vec++; if (dip1 !== 8'h7E) begin n_err++; $display("FAIL cfg_dip1 got %h exp 7e", dip1); end
        n_vec++; if (dip0 !== 8'hFF) begin n_err++; $display("FAIL cfg_dip0 got %h exp ff", dip0); end
        send_byte(8'd254, 25'h9, 8'h11);
        n_vec++; if (dip1 !== 8'h7E) begin n_err++; $display("FAIL cfg_dip_drop got %h exp 7e", dip1); end
        n_vec++; if (dip0 !== 8'hFF) begin n_err++; $display("FAIL cfg_dip_drop0 got %h exp ff", dip0); end
        n_vec++; if (wait_cycles !== 0) begin n_err++; $display("FAIL cfg_wait got %0d exp 0", wait_cycles); end
        n_vec++; if (bus.port1_req !== 1'b0 || bus.port2_req !== 1'b0) begin
            n_err++; $display("FAIL cfg_reqs got %b%b exp 00", bus.port1_req, bus.port2_req); end
        n_vec++; if (rom_loaded !== 1'b0) begin n_err++; $display("FAIL cfg_rom_loaded got %b exp 0", rom_loaded); end
        bus.ioctl_download = 1'b0;
        tick();
    endtask

    task automatic test_rom_byte();
        bus.ioctl_index = 8'd0;
        bus.ioctl_download = 1'b1;
        tick();
        p1_delay = 3;
        send_byte(8'd0, 25'h00005, 8'hA5);
        n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL rom_timeout got %b exp 0", timed_out); end
        n_vec++; if (t1 !== 1) begin n_err++; $display("FAIL rom_req1_toggles got %0d exp 1", t1); end
        n_vec++; if (t2 !== 0) begin n_err++; $display("FAIL rom_req2_toggles got %0d exp 0", t2); end
        n_vec++; if (c_p1_a !== 23'h2) begin n_err++; $display("FAIL rom_port1_a got %h exp 2", c_p1_a); end
        n_vec++; if (c_p1_ds !== 2'b10) begin n_err++; $display("FAIL rom_port1_ds got %b exp 10", c_p1_ds); end
        n_vec++; if (c_p1_d !== 16'hA5A5) begin n_err++; $display("FAIL rom_port1_d got %h exp a5a5", c_p1_d); end
        n_vec++; if (c_p1_we !== 1'b1) begin n_err++; $display("FAIL rom_port1_we got %b exp 1", c_p1_we); end
        n_vec++; if (wait_cycles !== 5) begin n_err++; $display("FAIL rom_wait_len got %0d exp 5", wait_cycles); end
        n_vec++; if (prom_pulses !== 0) begin n_err++; $display("FAIL rom_prom_wr got %0d exp 0", prom_pulses); end
    endtask

    task automatic test_sprite_byte();
        p2_delay = 10;
        send_byte(8'd0, 25'h30001, 8'h5A);
        n_vec++; if (t1 !== 1 || t2 !== 1) begin n_err++; $display("FAIL spr_toggles got %0d/%0d exp 1/1", t1, t2); end
        n_vec++; if (c_p2_a !== 23'h0) begin n_err++; $display("FAIL spr_port2_a got %h exp 0", c_p2_a); end
        n_vec++; if (c_p2_ds !== 2'b10) begin n_err++; $display("FAIL spr_port2_ds got %b exp 10", c_p2_ds); end
        n_vec++; if (c_p2_d !== 16'h5A5A) begin n_err++; $display("FAIL spr_port2_d got %h exp 5a5a", c_p2_d); end
        n_vec++; if (c_p1_a !== 23'h18000) begin n_err++; $display("FAIL spr_port1_a got %h exp 18000", c_p1_a); end
        n_vec++; if (wait_cycles !== 12) begin n_err++; $display("FAIL spr_wait_len got %0d exp 12", wait_cycles); end
        p2_delay = 3;
    endtask

    task automatic test_prom();
        send_byte(8'd0, 25'hA0300, 8'h3C);
        n_vec++; if (prom_pulses !== 1) begin n_err++; $display("FAIL prom_pulses got %0d exp 1", prom_pulses); end
        n_vec++; if (c_prom_addr !== 12'h300) begin n_err++; $display("FAIL prom_addr got %h exp 300", c_prom_addr); end
        n_vec++; if (c_prom_data !== 8'h3C) begin n_err++; $display("FAIL prom_data got %h exp 3c", c_prom_data); end
        n_vec++; if (t1 !== 1 || t2 !== 0) begin n_err++; $display("FAIL prom_toggles got %0d/%0d exp 1/0", t1, t2); end
        n_vec++; if (c_p1_a !== 23'h50180 || c_p1_ds !== 2'b01) begin
            n_err++; $display("FAIL prom_port1 got %h/%b exp 50180/01", c_p1_a, c_p1_ds); end
        send_byte(8'd0, 25'hA091F, 8'hE1);
        n_vec++; if (prom_pulses !== 1 || c_prom_addr !== 12'h91F) begin
            n_err++; $display("FAIL prom_last got %0d@%h exp 1@91f", prom_pulses, c_prom_addr); end
        send_byte(8'd0, 25'hA0920, 8'h77);
        n_vec++; if (prom_pulses !== 0) begin n_err++; $display("FAIL prom_beyond got %0d exp 0", prom_pulses); end
        n_vec++; if (t1 !== 1) begin n_err++; $display("FAIL prom_beyond_req1 got %0d exp 1", t1); end
    endtask

    task automatic test_rom_loaded();
        int   n;
        logic prev;
        ack_hold = 1'b1;
        bus.ioctl_index = 8'd0; bus.ioctl_addr = 25'h10; bus.ioctl_dout = 8'h11;
        bus.ioctl_wr = 1'b1;
        repeat (3) tick();
        n_vec++; if (bus.ioctl_wait !== 1'b1) begin n_err++; $display("FAIL ld_wait_pending got %b exp 1", bus.ioctl_wait); end
        bus.ioctl_download = 1'b0;
        repeat (2) tick();
        n_vec++; if (rom_loaded !== 1'b0) begin n_err++; $display("FAIL ld_early got %b exp 0", rom_loaded); end
        ack_hold = 1'b0;
        n = 0; prev = rom_loaded;
        while (bus.ioctl_wait && n < 20) begin prev = rom_loaded; tick(); n++; end
        n_vec++; if (n >= 20) begin n_err++; $display("FAIL ld_ack_timeout got %0d exp <20", n); end
        n_vec++; if (rom_loaded !== 1'b1 || prev !== 1'b0) begin
            n_err++; $display("FAIL ld_on_idle got %b (before %b) exp 1 (before 0)", rom_loaded, prev); end
        bus.ioctl_wr = 1'b0;
        $display("rom_loaded set on return to idle");
        n = 0;
        while (core_reset && n < 40) begin tick(); n++; end
        n_vec++; if (n !== 17) begin n_err++; $display("FAIL ld_core_reset_len got %0d exp 17", n); end
        reset_req = 1'b1;
        tick();
        reset_req = 1'b0;
        tick();
        n = 1;
        n_vec++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL rreq_reload got %b exp 1", core_reset); end
        while (core_reset && n < 40) begin tick(); n++; end
        n_vec++; if (n !== 17) begin n_err++; $display("FAIL rreq_len got %0d exp 17", n); end
        $display("reset_req pulse stretched %0d cycles", n);
    endtask

    task automatic test_reset_mid_transfer();
        bus.ioctl_index = 8'd0;
        bus.ioctl_download = 1'b1;
        tick();
        ack_hold = 1'b1;
        bus.ioctl_addr = 25'h20; bus.ioctl_dout = 8'h99; bus.ioctl_wr = 1'b1;
        repeat (3) tick();
        n_vec++; if (bus.ioctl_wait !== 1'b1) begin n_err++; $display("FAIL mid_wait got %b exp 1", bus.ioctl_wait); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.ioctl_wait !== 1'b0) begin n_err++; $display("FAIL mid_rst_wait got %b exp 0", bus.ioctl_wait); end
        n_vec++; if (bus.port1_req !== 1'b0) begin n_err++; $display("FAIL mid_rst_req1 got %b exp 0", bus.port1_req); end
        n_vec++; if (rom_loaded !== 1'b0) begin n_err++; $display("FAIL mid_rst_loaded got %b exp 0", rom_loaded); end
        n_vec++; if (core_reset !== 1'b1) begin n_err++; $display("FAIL mid_rst_core_reset got %b exp 1", core_reset); end
        n_vec++; if (core_mod !== 8'h00 || dip1 !== 8'hFF) begin
            n_err++; $display("FAIL mid_rst_cfg got %h/%h exp 00/ff", core_mod, dip1); end
        ack_hold = 1'b0;
        bus.ioctl_wr = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        send_byte(8'd0, 25'h00007, 8'hC3);
        n_vec++; if (timed_out !== 1'b0 || t1 !== 1) begin
            n_err++; $display("FAIL post_rst_req got %0d (timeout %b) exp 1", t1, timed_out); end
        n_vec++; if (wait_cycles !== 5) begin n_err++; $display("FAIL post_rst_wait got %0d exp 5", wait_cycles); end
        n_vec++; if (c_p1_a !== 23'h3 || c_p1_ds !== 2'b10 || c_p1_d !== 16'hC3C3) begin
            n_err++; $display("FAIL post_rst_port1 got %h/%b/%h exp 3/10/c3c3", c_p1_a, c_p1_ds, c_p1_d); end
    endtask

    initial begin
        test_reset();
        test_config();
        test_rom_byte();
        test_sprite_byte();
        test_prom();
        test_rom_loaded();
        test_reset_mid_transfer();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
